// File: rtl/rr_arb_pkg.sv
// Shared constants and state encoding for the round-robin one-hot arbiter.
// Optional feature macro used by the arbiter: RR_ARB_LOCK_EN (burst lock).
package rr_arb_pkg;

  localparam int NUM_REQ = 8;
  localparam int IDX_W   = 3;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  localparam logic [NUM_REQ-1:0] ONEHOT_ZERO = 8'h00;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin pick: rotate req so ptr sits at bit 0,
// take the lowest set bit, then rotate the result back.
module rr_pick
  import rr_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] pick_onehot,
  output logic [IDX_W-1:0]   pick_idx,
  output logic               pick_any
);

  logic [2*NUM_REQ-1:0] dbl;
  logic [NUM_REQ-1:0]   rot;
  logic [IDX_W-1:0]     rot_idx;

  always_comb begin
    dbl     = {req, req} >> ptr;
    rot     = dbl[NUM_REQ-1:0];
    rot_idx = '0;
    // Scan downward so the lowest set bit of the rotated vector wins.
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (rot[i]) rot_idx = IDX_W'(i);
    end
    pick_any    = |req;
    pick_idx    = rot_idx + ptr;
    pick_onehot = pick_any ? (NUM_REQ'(1) << pick_idx) : ONEHOT_ZERO;
  end

endmodule

// File: rtl/rr_onehot_arbiter.sv
// Round-robin arbiter over 8 requesters with a registered one-hot grant and
// valid/ready handshake. Define RR_ARB_LOCK_EN to add the burst-lock input.
module rr_onehot_arbiter
  import rr_arb_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_REQ-1:0]  req,
  output logic [NUM_REQ-1:0]  grant_onehot,
  output logic                grant_valid,
  input  logic                grant_ready,
`ifdef RR_ARB_LOCK_EN
  input  logic                lock,
`endif
  output logic                busy
);

  state_t               state_q, state_d;
  logic [IDX_W-1:0]     ptr_q, ptr_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [NUM_REQ-1:0]   grant_q, grant_d;

  logic                 handshake;
  logic                 hold_winner;
  logic [IDX_W-1:0]     ptr_adv;
  logic [IDX_W-1:0]     pick_ptr;
  logic [NUM_REQ-1:0]   pick_onehot;
  logic [IDX_W-1:0]     pick_idx;
  logic                 pick_any;

  assign handshake = (state_q == GRANT) && grant_ready;

`ifdef RR_ARB_LOCK_EN
  // Lock only holds priority while the current winner is still asking.
  assign hold_winner = lock && req[idx_q];
`else
  assign hold_winner = 1'b0;
`endif

  assign ptr_adv  = hold_winner ? idx_q : idx_q + IDX_W'(1);
  // On a handshake the re-arbitration must already see the advanced pointer.
  assign pick_ptr = handshake ? ptr_adv : ptr_q;

  rr_pick u_pick (
    .req         (req),
    .ptr         (pick_ptr),
    .pick_onehot (pick_onehot),
    .pick_idx    (pick_idx),
    .pick_any    (pick_any)
  );

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    idx_d   = idx_q;
    grant_d = grant_q;
    case (state_q)
      IDLE: begin
        if (pick_any) begin
          grant_d = pick_onehot;
          idx_d   = pick_idx;
          state_d = GRANT;
        end
      end
      GRANT: begin
        if (grant_ready) begin
          ptr_d = ptr_adv;
          if (pick_any) begin
            grant_d = pick_onehot;
            idx_d   = pick_idx;
          end else begin
            grant_d = ONEHOT_ZERO;
            state_d = IDLE;
          end
        end
      end
      default: begin
        grant_d = ONEHOT_ZERO;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      idx_q   <= '0;
      grant_q <= ONEHOT_ZERO;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      idx_q   <= idx_d;
      grant_q <= grant_d;
    end
  end

  assign grant_onehot = grant_q;
  assign grant_valid  = (state_q == GRANT);
  assign busy         = (state_q == GRANT);

endmodule

// File: tb/tb_rr_onehot_arbiter.sv
// Self-checking bench for rr_onehot_arbiter: directed scenarios plus random
// traffic against a behavioural round-robin model.
module tb_rr_onehot_arbiter;

  logic       clk;
  logic       rst_n;
  logic [7:0] req;
  logic [7:0] grant_onehot;
  logic       grant_valid;
  logic       grant_ready;
  logic       lock;
  logic       busy;

  int checks;
  int failures;

`ifdef RR_ARB_LOCK_EN
  localparam bit LOCK_EN = 1'b1;
`else
  localparam bit LOCK_EN = 1'b0;
`endif

  // Behavioural model state: is a grant live, who holds it, who has priority.
  bit m_valid;
  int m_win;
  int m_ptr;

  rr_onehot_arbiter dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req          (req),
    .grant_onehot (grant_onehot),
    .grant_valid  (grant_valid),
    .grant_ready  (grant_ready),
`ifdef RR_ARB_LOCK_EN
    .lock         (lock),
`endif
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int scan(input logic [7:0] r, input int p);
    for (int k = 0; k < 8; k++) begin
      if (r[(p + k) % 8]) return (p + k) % 8;
    end
    return -1;
  endfunction

  task automatic model_step(input logic r_n, input logic [7:0] r, input logic rdy, input logic lk);
    int w;
    if (!r_n) begin
      m_valid = 1'b0;
      m_ptr   = 0;
    end else if (!m_valid) begin
      w = scan(r, m_ptr);
      if (w >= 0) begin
        m_valid = 1'b1;
        m_win   = w;
      end
    end else if (rdy) begin
      if (LOCK_EN && lk && r[m_win]) m_ptr = m_win;
      else                           m_ptr = (m_win + 1) % 8;
      w = scan(r, m_ptr);
      if (w >= 0) m_win = w;
      else        m_valid = 1'b0;
    end
  endtask

  function automatic logic [7:0] m_grant();
    return m_valid ? (8'h01 << m_win) : 8'h00;
  endfunction

  // One clock: drive on the falling edge, sample 1 time unit after the rise.
  task automatic cycle(input logic r_n, input logic [7:0] r, input logic rdy, input logic lk);
    @(negedge clk);
    rst_n       = r_n;
    req         = r;
    grant_ready = rdy;
    lock        = lk;
    model_step(r_n, r, rdy, lk);
    @(posedge clk);
    #1;
    chk("grant", 32'(grant_onehot), 32'(m_grant()));
    chk("valid", 32'(grant_valid), 32'(m_valid));
    chk("busy", 32'(busy), 32'(m_valid));
    chk("onehot", 32'($countones(grant_onehot) <= 1), 32'd1);
  endtask

  initial begin
    checks      = 0;
    failures    = 0;
    m_valid     = 1'b0;
    m_win       = 0;
    m_ptr       = 0;
    rst_n       = 1'b0;
    req         = 8'h00;
    grant_ready = 1'b0;
    lock        = 1'b0;

    cycle(1'b0, 8'h00, 1'b0, 1'b0);
    chk("reset_grant", 32'(grant_onehot), 32'h00);
    chk("reset_valid", 32'(grant_valid), 32'd0);

    // Single request with a stalled consumer.
    cycle(1'b1, 8'h20, 1'b0, 1'b0);
    chk("single_grant", 32'(grant_onehot), 32'h20);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 8'h20, 1'b0, 1'b0);
      chk("stall_hold", 32'(grant_onehot), 32'h20);
    end
    cycle(1'b1, 8'h00, 1'b1, 1'b0);
    chk("single_idle", 32'({grant_valid, grant_onehot}), 32'h000);

    // Wrap and skip: pointer now 6.
    cycle(1'b1, 8'h09, 1'b0, 1'b0);
    chk("wrap_grant", 32'(grant_onehot), 32'h01);
    cycle(1'b1, 8'h09, 1'b1, 1'b0);
    chk("skip_grant", 32'(grant_onehot), 32'h08);
    cycle(1'b1, 8'h00, 1'b1, 1'b0);

    // Request drops while granted: grant held until accepted.
    cycle(1'b1, 8'h04, 1'b0, 1'b0);
    chk("drop_grant", 32'(grant_onehot), 32'h04);
    cycle(1'b1, 8'h00, 1'b0, 1'b0);
    cycle(1'b1, 8'h00, 1'b0, 1'b0);
    chk("drop_hold", 32'({grant_valid, grant_onehot}), 32'h104);
    cycle(1'b1, 8'h00, 1'b1, 1'b0);
    chk("drop_idle", 32'(grant_valid), 32'd0);

    // Reset mid-grant on bit 4, then full rotation from pointer 0.
    cycle(1'b1, 8'h10, 1'b0, 1'b0);
    chk("mid_grant", 32'(grant_onehot), 32'h10);
    cycle(1'b0, 8'h10, 1'b0, 1'b0);
    chk("mid_reset", 32'({busy, grant_valid, grant_onehot}), 32'h000);
    cycle(1'b1, 8'hFF, 1'b0, 1'b0);
    chk("post_reset", 32'(grant_onehot), 32'h01);
    for (int i = 1; i <= 9; i++) begin
      cycle(1'b1, 8'hFF, 1'b1, 1'b0);
      chk("rotate", 32'(grant_onehot), 32'(8'h01 << (i % 8)));
    end
    cycle(1'b1, 8'h00, 1'b1, 1'b0);

`ifdef RR_ARB_LOCK_EN
    cycle(1'b0, 8'h00, 1'b0, 1'b0);
    cycle(1'b1, 8'h06, 1'b0, 1'b0);
    chk("lock_first", 32'(grant_onehot), 32'h02);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 8'h06, 1'b1, 1'b1);
      chk("lock_hold", 32'(grant_onehot), 32'h02);
    end
    cycle(1'b1, 8'h06, 1'b1, 1'b0);
    chk("lock_release", 32'(grant_onehot), 32'h04);
    cycle(1'b1, 8'h00, 1'b1, 1'b0);
`endif

    // Random traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      logic       r_n;
      logic [7:0] r;
      r_n = ($urandom_range(0, 63) != 0);
      r   = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
      cycle(r_n, r, 1'($urandom), 1'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
